// File: rtl/vga_pkg.sv
// Shared VGA raster types and default 640x480@60 timing constants.
package vga_pkg;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } vga_region_t;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    function automatic int axis_total(input int visible, input int front,
                                      input int sync_w, input int back);
        return visible + front + sync_w + back;
    endfunction

    localparam int H_TOTAL_DEF = axis_total(H_VISIBLE_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
    localparam int V_TOTAL_DEF = axis_total(V_VISIBLE_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);

    // Region boundaries are laid out visible -> front porch -> sync -> back porch.
    function automatic vga_region_t region_of(input coord_t c, input int visible,
                                              input int front, input int sync_w);
        if (int'(c) < visible)
            return ACTIVE;
        else if (int'(c) < visible + front)
            return FRONT;
        else if (int'(c) < visible + front + sync_w)
            return SYNC;
        else
            return BACK;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus registered region/sync/last flags,
// all derived from the next count so they line up with the count output.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int N_VISIBLE = 640,
    parameter int N_FRONT   = 16,
    parameter int N_SYNC    = 96,
    parameter int N_BACK    = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        wrap,
    output coord_t      count,
    output vga_region_t region,
    output logic        sync_n,
    output logic        last
);

    localparam int     TOTAL = axis_total(N_VISIBLE, N_FRONT, N_SYNC, N_BACK);
    localparam coord_t LAST  = coord_t'(TOTAL - 1);

    if (TOTAL > 1024) begin : g_total_check
        $error("vga_axis_counter: axis total %0d exceeds 1024", TOTAL);
    end

    coord_t      count_next;
    vga_region_t region_next;

    always_comb begin
        count_next = count;
        if (enable)
            count_next = wrap ? '0 : count + coord_t'(1);
        region_next = region_of(count_next, N_VISIBLE, N_FRONT, N_SYNC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            region <= ACTIVE;
            sync_n <= 1'b1;
            last   <= 1'b0;
        end else begin
            count  <= count_next;
            region <= region_next;
            sync_n <= (region_next != SYNC);
            last   <= (count_next == LAST);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: Clk/2 pixel enable driving cascaded H/V axis counters.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF
) (
    input  logic         Clk,
    input  logic         Reset,
    output logic         pixel_clk,
    output logic         pix_ce,
    output logic [9:0]   DrawX,
    output logic [9:0]   DrawY,
    output logic         VGA_HS,
    output logic         VGA_VS,
    output logic         VGA_BLANK_N,
    output logic         frame_end
);

    vga_region_t h_region;
    vga_region_t v_region;
    logic        h_last;
    logic        v_last;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            pixel_clk <= 1'b0;
        else
            pixel_clk <= ~pixel_clk;
    end

    assign pix_ce = pixel_clk;

    vga_axis_counter #(
        .N_VISIBLE(H_VISIBLE),
        .N_FRONT  (H_FRONT),
        .N_SYNC   (H_SYNC),
        .N_BACK   (H_BACK)
    ) u_h_axis (
        .clk    (Clk),
        .rst    (Reset),
        .enable (pix_ce),
        .wrap   (h_last),
        .count  (DrawX),
        .region (h_region),
        .sync_n (VGA_HS),
        .last   (h_last)
    );

    // The vertical axis only steps on the pixel that ends a line.
    vga_axis_counter #(
        .N_VISIBLE(V_VISIBLE),
        .N_FRONT  (V_FRONT),
        .N_SYNC   (V_SYNC),
        .N_BACK   (V_BACK)
    ) u_v_axis (
        .clk    (Clk),
        .rst    (Reset),
        .enable (pix_ce & h_last),
        .wrap   (v_last),
        .count  (DrawY),
        .region (v_region),
        .sync_n (VGA_VS),
        .last   (v_last)
    );

    assign VGA_BLANK_N = (h_region == ACTIVE) && (v_region == ACTIVE);
    assign frame_end   = pix_ce & h_last & v_last;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized-reset bench comparing a default and a reduced-size raster against a time-based model.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       pclk;
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       bn;
        logic       fe;
    } exp_t;

    logic       Clk = 1'b0;
    logic       Reset;

    logic       d_pclk, d_pce, d_hs, d_vs, d_bn, d_fe;
    logic [9:0] d_x, d_y;
    logic       s_pclk, s_pce, s_hs, s_vs, s_bn, s_fe;
    logic [9:0] s_x, s_y;

    int n_vec = 0;
    int n_err = 0;
    int n_edges;

    always #10 Clk = ~Clk;

    vga_timing_gen dut_d (
        .Clk        (Clk),
        .Reset      (Reset),
        .pixel_clk  (d_pclk),
        .pix_ce     (d_pce),
        .DrawX      (d_x),
        .DrawY      (d_y),
        .VGA_HS     (d_hs),
        .VGA_VS     (d_vs),
        .VGA_BLANK_N(d_bn),
        .frame_end  (d_fe)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
    ) dut_s (
        .Clk        (Clk),
        .Reset      (Reset),
        .pixel_clk  (s_pclk),
        .pix_ce     (s_pce),
        .DrawX      (s_x),
        .DrawY      (s_y),
        .VGA_HS     (s_hs),
        .VGA_VS     (s_vs),
        .VGA_BLANK_N(s_bn),
        .frame_end  (s_fe)
    );

    // Expected outputs after n clock edges since reset release, from raster position arithmetic.
    function automatic exp_t model(input int n, input int hv, input int hf, input int hsw, input int hb,
                                   input int vv, input int vf, input int vsw, input int vb);
        exp_t e;
        int ht, vt, k, x, y;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        k  = (n / 2) % (ht * vt);
        x  = k % ht;
        y  = k / ht;
        e.pclk = (n % 2) == 1;
        e.x    = 10'(x);
        e.y    = 10'(y);
        e.hs   = !((x >= hv + hf) && (x < hv + hf + hsw));
        e.vs   = !((y >= vv + vf) && (y < vv + vf + vsw));
        e.bn   = (x < hv) && (y < vv);
        e.fe   = ((n % 2) == 1) && (x == ht - 1) && (y == vt - 1);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", tag, obs, exp, n_edges, $time);
        end
    endtask

    task automatic compare_both(input int n);
        exp_t ed, es;
        ed = model(n, 640, 16, 96, 48, 480, 10, 2, 33);
        es = model(n, 8, 2, 2, 2, 4, 1, 1, 1);
        check("d_pixel_clk", 32'(d_pclk), 32'(ed.pclk));
        check("d_pix_ce",    32'(d_pce),  32'(ed.pclk));
        check("d_DrawX",     32'(d_x),    32'(ed.x));
        check("d_DrawY",     32'(d_y),    32'(ed.y));
        check("d_VGA_HS",    32'(d_hs),   32'(ed.hs));
        check("d_VGA_VS",    32'(d_vs),   32'(ed.vs));
        check("d_BLANK_N",   32'(d_bn),   32'(ed.bn));
        check("d_frame_end", 32'(d_fe),   32'(ed.fe));
        check("s_pixel_clk", 32'(s_pclk), 32'(es.pclk));
        check("s_pix_ce",    32'(s_pce),  32'(es.pclk));
        check("s_DrawX",     32'(s_x),    32'(es.x));
        check("s_DrawY",     32'(s_y),    32'(es.y));
        check("s_VGA_HS",    32'(s_hs),   32'(es.hs));
        check("s_VGA_VS",    32'(s_vs),   32'(es.vs));
        check("s_BLANK_N",   32'(s_bn),   32'(es.bn));
        check("s_frame_end", 32'(s_fe),   32'(es.fe));
    endtask

    initial begin
        Reset   = 1'b1;
        n_edges = 0;
        repeat (3) @(posedge Clk);
        #1 compare_both(0);
        @(negedge Clk);
        Reset = 1'b0;

        for (int seg = 0; seg < 8; seg++) begin
            int len;
            len = (seg == 0) ? 5000 : int'($urandom_range(150, 2500));
            repeat (len) begin
                @(posedge Clk);
                n_edges++;
                #1 compare_both(n_edges);
            end
            // Reset lands between clock edges; outputs must drop to reset values at once.
            #2 Reset = 1'b1;
            #1 compare_both(0);
            repeat (int'($urandom_range(1, 3))) @(posedge Clk);
            #1 compare_both(0);
            @(negedge Clk);
            Reset   = 1'b0;
            n_edges = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

- Generates 640x480@60 Hz VGA raster timing from the 50 MHz system clock.
- Drives the pixel coordinates `DrawX`/`DrawY` consumed by `color_mapper`, plus the sync/blank signals paired with its RGB outputs.
- Emits a one-cycle `frame_end` strobe. Game logic latches piece coordinates on this strobe so they stay stable for the whole displayed frame.

## Interface
Parameters:
- `H_VISIBLE`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch
- `H_SYNC`, 96, horizontal sync width
- `H_BACK`, 48, horizontal back porch
- `V_VISIBLE`, 480, visible lines
- `V_FRONT`, 10, vertical front porch
- `V_SYNC`, 2, vertical sync width
- `V_BACK`, 33, vertical back porch

Ports:
- `Clk` in 1: system clock, 50 MHz. One clock; reset is asynchronous and active-high.
- `Reset` in 1: asynchronous, active-high.
- `pixel_clk` out 1: Clk/2 toggle. Reset 0.
- `pix_ce` out 1: pixel advance enable; equals `pixel_clk`. Reset 0.
- `DrawX` out 10: current column, 0..799. Reset 0.
- `DrawY` out 10: current line, 0..524. Reset 0.
- `VGA_HS` out 1: horizontal sync, active low. Reset 1.
- `VGA_VS` out 1: vertical sync, active low. Reset 1.
- `VGA_BLANK_N` out 1: high in the visible region. Reset 1.
- `frame_end` out 1: one-Clk strobe on the last pixel of a frame. Reset 0.

## Operation
- `pixel_clk` toggles on every Clk edge. Counters update only on Clk edges where `pix_ce`=1.
- Horizontal FSM, state from `DrawX`. Defaults: 640/16/96/48, total `H_TOTAL` = 800.
  - `H_ACTIVE`: 0..639
  - `H_FP`: 640..655
  - `H_SYNC`: 656..751, `VGA_HS`=0
  - `H_BP`: 752..799
- Horizontal wrap: at `DrawX`=799 with `pix_ce`, `DrawX`→0 and `DrawY` increments.
- Vertical FSM, same structure: `V_ACTIVE` 0..479, `V_FP` 480..489, `V_SYNC` 490..491 (`VGA_VS`=0), `V_BP` 492..524. Total `V_TOTAL` = 525.
- Frame wrap: at (799,524) with `pix_ce`, both counters→0.
- `VGA_BLANK_N` = (`DrawX`<640) && (`DrawY`<480).
- `frame_end` = `pix_ce` && `DrawX`=799 && `DrawY`=524.
- Arithmetic:
  - Counters are 10-bit unsigned.
  - Totals must be ≤1024; elaboration fails otherwise.
  - Counters never exceed total−1 and use no modular overflow.
- Reset mid-operation: all outputs return to their reset values immediately, asynchronously. Raster restarts at (0,0) after release.

## Timing
- Sync and blank are registered from the next-state counter values, so they are cycle-aligned with `DrawX`/`DrawY` (zero relative latency).
- After `Reset` deasserts:
  - `pixel_clk`=1 after the 1st Clk edge.
  - `DrawX`=1 after the 2nd edge.
- Each pixel coordinate holds for exactly 2 Clk cycles.
- Line = 1600 Clk. Frame = 840000 Clk.
- `VGA_HS` low for 192 Clk per line.
- `VGA_VS` low for 3200 Clk per frame.
- `frame_end` is high for exactly 1 Clk per frame. The next edge shows `DrawX`=`DrawY`=0.

## Structure
- Shared package `vga_pkg`:
  - default timing constants
  - `H_TOTAL`/`V_TOTAL` derivation
  - `typedef enum {ACTIVE, FRONT, SYNC, BACK} vga_region_t`
  - 10-bit `coord_t`
- Sub-module `vga_axis_counter`, instantiated twice (H, V):
  - inputs: enable, wrap
  - outputs: count, region, sync_n, last
  - horizontal `last` gates the vertical enable

## Test plan
- Reset held then released → all outputs at reset values; `DrawX`=1 after 2 edges; `DrawY`=0.
- Run one line → `DrawX` 799→0 and `DrawY` 0→1 on the same edge; `VGA_BLANK_N` falls at `DrawX`=640.
- Measure HS → low exactly for `DrawX` 656..751 (192 Clk). Measure VS → low exactly for lines 490..491.
- Run a full frame → `frame_end` one Clk wide at (799,524); 840000 Clk between strobes; next coordinates (0,0).
- Assert `Reset` at (300,200) between Clk edges → outputs 0/1 reset values immediately; raster restarts from (0,0).
- Instantiate with `H_VISIBLE`=8, `H_FRONT`=`H_SYNC`=`H_BACK`=2 → line total 14; HS low for `DrawX` 10..11.
